// File: rtl/stim_sequencer.sv
// stim_sequencer: replays stored stimulus steps into an external FSM and scores its outputs.
// Define STIM_SEQ_STOP_ON_ERR_EN to end a run at the first mismatching step.
module stim_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic          dut_n_reset,
  output logic          dut_a,
  output logic          dut_b,
  output logic          dut_c,
  input  logic          dut_s,
  input  logic          dut_t,
  input  logic          dut_k,
  input  logic          dut_l,
  input  logic          dut_n,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] err_step
);
  typedef enum logic [2:0] {IDLE, DUT_RST, APPLY, CHECK, FINISH} state_t;
  state_t        r_state, w_next;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_idx;
  logic [AW:0]   r_len;
  logic [AW:0]   r_err_count;
  logic [AW-1:0] r_err_step;
  logic          r_pass;
  logic          w_len_ok, w_accept, w_act, w_mis, w_last, w_stop;
  logic [7:0]    w_entry;
  assign w_len_ok = (len != '0) && (len <= (AW+1)'(DEPTH));
  assign w_accept = (r_state == IDLE) && start && w_len_ok;
  assign w_entry  = r_mem[r_idx];
  assign w_act    = (r_state == APPLY) || (r_state == CHECK);
  assign w_mis    = (r_state == CHECK) && ({dut_s, dut_t, dut_k, dut_l, dut_n} != w_entry[4:0]);
  assign w_last   = {1'b0, r_idx} == r_len - (AW+1)'(1);
`ifdef STIM_SEQ_STOP_ON_ERR_EN
  assign w_stop = w_mis;
`else
  assign w_stop = 1'b0;
`endif
  assign {dut_a, dut_b, dut_c} = w_act ? w_entry[7:5] : 3'b000;
  assign dut_n_reset = r_state != DUT_RST;
  assign busy        = (r_state == DUT_RST) || w_act;
  assign done        = r_state == FINISH;
  assign pass        = r_pass;
  assign err_count   = r_err_count;
  assign err_step    = r_err_step;
  // Step memory has no reset so stored programs survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (wr_en && r_state == IDLE) r_mem[wr_addr] <= wr_data;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_accept ? DUT_RST : IDLE;
      DUT_RST: w_next = APPLY;
      APPLY:   w_next = CHECK;
      CHECK:   w_next = (w_last || w_stop) ? FINISH : APPLY;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_err_count <= '0;
      r_err_step  <= '0;
      r_pass      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_len       <= len;
        r_idx       <= '0;
        r_err_count <= '0;
        r_err_step  <= '0;
        r_pass      <= 1'b0;
      end
      if (r_state == CHECK) begin
        if (w_mis && r_err_count != '1) r_err_count <= r_err_count + (AW+1)'(1);
        if (w_mis && r_err_count == '0) r_err_step <= r_idx;
        if (!w_last && !w_stop) r_idx <= r_idx + AW'(1);
      end
      if (r_state == FINISH) begin
        r_pass <= r_err_count == '0;
        r_idx  <= '0;
      end
    end
  end
endmodule
